// File: rtl/axi_pkg.sv
// Shared AXI encodings plus small helpers used by the SRAM slave.
// Burst/response codes, FSM state types and response-priority helpers.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Response codes are ordered by severity, so the worse one is simply the larger.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Only 32-bit INCR/FIXED bursts are fully supported; anything else answers SLVERR.
    function automatic logic burst_is_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_WORD) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

    // WRAP and the reserved code advance like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd4;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3-style bus bundle between a master and the SRAM slave.
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_sram_mem.sv
// Word-organised storage: one byte-enabled write port, one combinational read port.
// Contents are deliberately never reset.
module axi_sram_mem #(
    parameter int MEM_WORDS = 4096,
    parameter int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [3:0]       wbe_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    // One array per byte lane keeps each lane's write enable independent.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [MEM_WORDS];

        always_ff @(posedge clk) begin
            if (we_i && wbe_i[gi]) begin
                lane_q[waddr_i] <= wdata_i[gi*8 +: 8];
            end
        end

        assign rdata_o[gi*8 +: 8] = lane_q[raddr_i];
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI slave in front of a word SRAM: independent single-burst write and read FSMs,
// registered handshake outputs, read-first behaviour on same-cycle collisions.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_sram_slave_if.slave  s_axi
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    function automatic logic in_range(input logic [31:0] addr);
        return {1'b0, addr} < MEM_BYTES;
    endfunction

    // ---------------- write path ----------------
    wstate_e         wstate_q;
    logic            awready_q;
    logic            wready_q;
    logic            bvalid_q;
    logic [ID_W-1:0] bid_q;
    logic [1:0]      bresp_q;
    logic [31:0]     waddr_q;
    logic [3:0]      wlen_q;
    logic [1:0]      wburst_q;
    logic            werr_q;
    logic [3:0]      wcnt_q;

    logic            wbeat_fire_d;
    logic            wbeat_last_d;
    logic [1:0]      wbeat_resp_d;
    logic            mem_we_d;

    always_comb begin
        wbeat_fire_d = (wstate_q == W_DATA) && s_axi.wvalid && wready_q;
        wbeat_last_d = (wcnt_q == wlen_q);
        wbeat_resp_d = RESP_OKAY;
        if (!in_range(waddr_q)) begin
            wbeat_resp_d = RESP_DECERR;
        end else if (s_axi.wlast != wbeat_last_d) begin
            wbeat_resp_d = RESP_SLVERR;
        end
        mem_we_d = wbeat_fire_d && !werr_q && in_range(waddr_q);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (s_axi.awvalid && awready_q) begin
                        wstate_q  <= W_DATA;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= s_axi.awid;
                        waddr_q   <= s_axi.awaddr;
                        wlen_q    <= s_axi.awlen;
                        wburst_q  <= s_axi.awburst;
                        werr_q    <= burst_is_err(s_axi.awsize, s_axi.awburst);
                        bresp_q   <= burst_is_err(s_axi.awsize, s_axi.awburst) ? RESP_SLVERR : RESP_OKAY;
                        wcnt_q    <= '0;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wbeat_fire_d) begin
                        bresp_q <= resp_merge(bresp_q, wbeat_resp_d);
                        waddr_q <= next_addr(waddr_q, wburst_q);
                        wcnt_q  <= wcnt_q + 4'd1;
                        // The beat count, not wlast, terminates the burst.
                        if (wbeat_last_d) begin
                            wstate_q <= W_RESP;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && s_axi.bready) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rstate_e         rstate_q;
    logic            arready_q;
    logic            rvalid_q;
    logic            rlast_q;
    logic [1:0]      rresp_q;
    logic [ID_W-1:0] rid_q;
    logic [31:0]     rdata_q;
    logic [31:0]     raddr_q;
    logic [3:0]      rlen_q;
    logic [1:0]      rburst_q;
    logic            rerr_q;
    logic [3:0]      rcnt_q;

    logic [31:0]     rd_addr_d;
    logic            rd_err_d;
    logic [1:0]      rd_resp_d;
    logic [31:0]     rd_data_d;
    logic            rd_last_d;
    logic [31:0]     mem_rdata;

    // In idle the array is looked up with the incoming request so the first
    // beat can be registered on the handshake edge.
    always_comb begin
        if (rstate_q == R_IDLE) begin
            rd_addr_d = s_axi.araddr;
            rd_err_d  = burst_is_err(s_axi.arsize, s_axi.arburst);
            rd_last_d = (s_axi.arlen == 4'd0);
        end else begin
            rd_addr_d = next_addr(raddr_q, rburst_q);
            rd_err_d  = rerr_q;
            rd_last_d = ((rcnt_q + 4'd1) == rlen_q);
        end
        rd_resp_d = RESP_OKAY;
        rd_data_d = mem_rdata;
        if (!in_range(rd_addr_d)) begin
            rd_resp_d = RESP_DECERR;
            rd_data_d = '0;
        end else if (rd_err_d) begin
            rd_resp_d = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s_axi.arvalid && arready_q) begin
                        rstate_q  <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= s_axi.arid;
                        raddr_q   <= s_axi.araddr;
                        rlen_q    <= s_axi.arlen;
                        rburst_q  <= s_axi.arburst;
                        rerr_q    <= rd_err_d;
                        rcnt_q    <= '0;
                        rdata_q   <= rd_data_d;
                        rresp_q   <= rd_resp_d;
                        rlast_q   <= rd_last_d;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    // Payload only moves on a handshake, so it holds through stalls.
                    if (rvalid_q && s_axi.rready) begin
                        if (rlast_q) begin
                            rstate_q  <= R_IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            raddr_q <= rd_addr_d;
                            rcnt_q  <= rcnt_q + 4'd1;
                            rdata_q <= rd_data_d;
                            rresp_q <= rd_resp_d;
                            rlast_q <= rd_last_d;
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    axi_sram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we_d),
        .waddr_i (waddr_q[IDX_W+1:2]),
        .wbe_i   (s_axi.wstrb),
        .wdata_i (s_axi.wdata),
        .raddr_i (rd_addr_d[IDX_W+1:2]),
        .rdata_o (mem_rdata)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, stalls, error responses,
// concurrent read/write and reset mid-burst.
module tb_axi_sram_slave;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    axi_sram_slave_if #(.ID_W(4)) bus ();

    axi_sram_slave #(
        .ID_W      (4),
        .MEM_WORDS (4096)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [31:0] old_w   [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("aw_handshake", 32'(bus.awready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        while (bus.wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("w_handshake", 32'(bus.wready), 32'd1);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic b_phase();
        int n = 0;
        bus.bready = 1'b1;
        while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("b_handshake", 32'(bus.bvalid), 32'd1);
        b_resp = bus.bresp;
        b_id   = bus.bid;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                             input bit bad_wlast);
        aw_phase(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            w_beat(wr_data[i], strb, bad_wlast ? (i == 0) : (i == int'(len)));
        end
        b_phase();
        $display("WR id=%h addr=%h len=%0d size=%0d burst=%0d strb=%h -> bid=%h bresp=%0d",
                 id, addr, len, size, burst, strb, b_id, b_resp);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int n = 0;
        int beat = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] sd;
        logic [3:0]  si;
        logic [1:0]  sr;
        logic        sl;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("ar_handshake", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        while (beat <= int'(len) && cyc < 200) begin
            bus.rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (bus.rvalid === 1'b1) begin
                if (stalled) begin
                    chk("r_hold_data", bus.rdata, sd);
                    chk("r_hold_id",   32'(bus.rid), 32'(si));
                    chk("r_hold_resp", 32'(bus.rresp), 32'(sr));
                    chk("r_hold_last", 32'(bus.rlast), 32'(sl));
                end
                if (bus.rready) begin
                    rd_data[beat] = bus.rdata; rd_resp[beat] = bus.rresp;
                    rd_last[beat] = bus.rlast; rd_id[beat]   = bus.rid;
                    beat++;
                    stalled = 0;
                end else begin
                    sd = bus.rdata; si = bus.rid; sr = bus.rresp; sl = bus.rlast;
                    stalled = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        chk("r_beat_count", 32'(beat), 32'(len) + 32'd1);
        $display("RD id=%h addr=%h len=%0d size=%0d burst=%0d toggle=%0d -> beats=%0d data0=%h resp0=%0d",
                 id, addr, len, size, burst, toggle, beat, rd_data[0], rd_resp[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready",  32'(bus.wready),  32'd0);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_rlast",   32'(bus.rlast),   32'd0);
        chk("rst_bresp",   32'(bus.bresp),   32'd0);
        chk("rst_rresp",   32'(bus.rresp),   32'd0);
        chk("rst_bid",     32'(bus.bid),     32'd0);
        chk("rst_rid",     32'(bus.rid),     32'd0);
        chk("rst_rdata",   bus.rdata,        32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rel_awready", 32'(bus.awready), 32'd1);
        chk("rel_arready", 32'(bus.arready), 32'd1);

        // INCR 4-beat write and readback at 0x1000
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
        axi_write(4'h3, 32'h1000, 4'd3, 3'b010, 2'b01, 4'hF, 0);
        chk("incr_bresp", 32'(b_resp), 32'd0);
        chk("incr_bid",   32'(b_id),   32'h3);
        axi_read(4'h3, 32'h1000, 4'd3, 3'b010, 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_rdata%0d", i), rd_data[i], 32'(i + 1));
            chk($sformatf("incr_rlast%0d", i), 32'(rd_last[i]), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("incr_rresp%0d", i), 32'(rd_resp[i]), 32'd0);
        end

        // Known contents for words 0..4, then a partial-strobe write over word 0
        wr_data[0] = 32'h0000_0000; wr_data[1] = 32'h1111_1111; wr_data[2] = 32'h2222_2222;
        wr_data[3] = 32'h3333_3333; wr_data[4] = 32'h4444_4444;
        axi_write(4'h1, 32'h0, 4'd4, 3'b010, 2'b01, 4'hF, 0);
        chk("fill0_bresp", 32'(b_resp), 32'd0);
        wr_data[0] = 32'hAABB_CCDD;
        axi_write(4'h2, 32'h0, 4'd0, 3'b010, 2'b01, 4'b0101, 0);
        chk("strb_bresp", 32'(b_resp), 32'd0);
        axi_read(4'h2, 32'h0, 4'd0, 3'b010, 2'b01, 0);
        chk("strb_rdata", rd_data[0], 32'h00BB_00DD);
        chk("strb_rlast", 32'(rd_last[0]), 32'd1);

        // 16-beat read with rready toggling
        for (int i = 0; i < 16; i++) wr_data[i] = 32'h2000_0000 + 32'(i);
        axi_write(4'h5, 32'h2000, 4'd15, 3'b010, 2'b01, 4'hF, 0);
        chk("fill2k_bresp", 32'(b_resp), 32'd0);
        axi_read(4'h5, 32'h2000, 4'd15, 3'b010, 2'b01, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("long_rdata%0d", i), rd_data[i], 32'h2000_0000 + 32'(i));
            chk($sformatf("long_rlast%0d", i), 32'(rd_last[i]), (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("long_rid%0d", i),   32'(rd_id[i]), 32'h5);
        end

        // Out-of-range write: DECERR, aliased word 0 untouched
        wr_data[0] = 32'hDEAD_BEEF;
        axi_write(4'h6, 32'h4000, 4'd0, 3'b010, 2'b01, 4'hF, 0);
        chk("oob_bresp", 32'(b_resp), 32'd3);
        axi_read(4'h6, 32'h0, 4'd0, 3'b010, 2'b01, 0);
        chk("oob_word0", rd_data[0], 32'h00BB_00DD);
        axi_read(4'h6, 32'h4000, 4'd0, 3'b010, 2'b01, 0);
        chk("oob_rresp", 32'(rd_resp[0]), 32'd3);
        chk("oob_rdata", rd_data[0], 32'd0);

        // Narrow size: SLVERR and no write
        axi_write(4'h7, 32'h10, 4'd0, 3'b001, 2'b01, 4'hF, 0);
        chk("size_bresp", 32'(b_resp), 32'd2);
        axi_read(4'h7, 32'h10, 4'd0, 3'b010, 2'b01, 0);
        chk("size_word4", rd_data[0], 32'h4444_4444);
        axi_read(4'h7, 32'h10, 4'd0, 3'b001, 2'b01, 0);
        chk("size_rresp", 32'(rd_resp[0]), 32'd2);

        // wlast on the wrong beat: still two beats, SLVERR
        wr_data[0] = 32'h5555_5555; wr_data[1] = 32'h6666_6666;
        axi_write(4'h8, 32'h20, 4'd1, 3'b010, 2'b01, 4'hF, 1);
        chk("wlast_bresp", 32'(b_resp), 32'd2);

        // WRAP reads advance like INCR with SLVERR; FIXED stays on one word
        axi_read(4'h9, 32'h0, 4'd1, 3'b010, 2'b10, 0);
        chk("wrap_rdata0", rd_data[0], 32'h00BB_00DD);
        chk("wrap_rdata1", rd_data[1], 32'h1111_1111);
        chk("wrap_rresp0", 32'(rd_resp[0]), 32'd2);
        chk("wrap_rresp1", 32'(rd_resp[1]), 32'd2);
        axi_read(4'hA, 32'h1000, 4'd2, 3'b010, 2'b00, 0);
        for (int i = 0; i < 3; i++) chk($sformatf("fixed_rdata%0d", i), rd_data[i], 32'd1);

        // Concurrent write and read of words 0..3: read sees pre-write data
        old_w[0] = 32'h00BB_00DD; old_w[1] = 32'h1111_1111;
        old_w[2] = 32'h2222_2222; old_w[3] = 32'h3333_3333;
        bus.awid = 4'hB; bus.awaddr = 32'h0; bus.awlen = 4'd3; bus.awsize = 3'b010; bus.awburst = 2'b01;
        bus.arid = 4'hC; bus.araddr = 32'h0; bus.arlen = 4'd3; bus.arsize = 3'b010; bus.arburst = 2'b01;
        bus.awvalid = 1'b1; bus.arvalid = 1'b1;
        chk("cc_awready", 32'(bus.awready), 32'd1);
        chk("cc_arready", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.wvalid = 1'b1; bus.wdata = 32'hC000_0000 + 32'(k); bus.wstrb = 4'hF; bus.wlast = (k == 3);
            bus.rready = 1'b1;
            chk($sformatf("cc_wready%0d", k), 32'(bus.wready), 32'd1);
            chk($sformatf("cc_rvalid%0d", k), 32'(bus.rvalid), 32'd1);
            chk($sformatf("cc_rdata%0d", k),  bus.rdata, old_w[k]);
            chk($sformatf("cc_rresp%0d", k),  32'(bus.rresp), 32'd0);
            chk($sformatf("cc_rlast%0d", k),  32'(bus.rlast), (k == 3) ? 32'd1 : 32'd0);
            $display("CC beat=%0d wdata=%h rdata=%h", k, bus.wdata, bus.rdata);
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.rready = 1'b0;
        chk("cc_rvalid_end", 32'(bus.rvalid), 32'd0);
        b_phase();
        chk("cc_bresp", 32'(b_resp), 32'd0);
        chk("cc_bid",   32'(b_id),   32'hB);
        axi_read(4'hC, 32'h0, 4'd3, 3'b010, 2'b01, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("cc_after%0d", i), rd_data[i], 32'hC000_0000 + 32'(i));

        // Reset in the middle of a write burst after two beats
        aw_phase(4'hD, 32'h3000, 4'd3, 3'b010, 2'b01);
        w_beat(32'h7777_0001, 4'hF, 1'b0);
        w_beat(32'h7777_0002, 4'hF, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_awready", 32'(bus.awready), 32'd0);
        chk("mid_rst_wready",  32'(bus.wready),  32'd0);
        chk("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("mid_rst_arready", 32'(bus.arready), 32'd0);
        chk("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rel_awready", 32'(bus.awready), 32'd1);
        chk("mid_rel_arready", 32'(bus.arready), 32'd1);
        chk("mid_rel_wready",  32'(bus.wready),  32'd0);
        chk("mid_rel_bvalid",  32'(bus.bvalid),  32'd0);
        axi_read(4'hE, 32'h3000, 4'd1, 3'b010, 2'b01, 0);
        chk("mid_keep0", rd_data[0], 32'h7777_0001);
        chk("mid_keep1", rd_data[1], 32'h7777_0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ID_W, default 4, AXI transaction ID width.
REQ-002 Parameter MEM_WORDS, default 4096, number of 32-bit words stored; byte capacity is MEM_WORDS*4.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 AW channel: awid in ID_W; awaddr in 32; awlen in 4; awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-006 W channel: wid in ID_W; wdata in 32; wstrb in 4; wlast in 1; wvalid in 1; wready out 1.
REQ-007 B channel: bid out ID_W; bresp out 2; bvalid out 1; bready in 1.
REQ-008 AR channel: arid in ID_W; araddr in 32; arlen in 4; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
REQ-009 R channel: rid out ID_W; rdata out 32; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Function
REQ-010 Write and read paths SHALL be independent FSMs, each handling one burst at a time, with no outstanding-transaction queue.
REQ-011 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
- AW handshake moves W_IDLE->W_DATA and latches id, addr, len, burst, and an error flag.
- Last W beat moves W_DATA->W_RESP.
- bvalid&&bready moves W_RESP->W_IDLE.
REQ-012 Beats accepted SHALL be counted to awlen+1 exactly; the beat with count==awlen ends the burst regardless of wlast.
- A wlast mismatch on any beat sets bresp=SLVERR (2'b10).
REQ-013 Each W beat SHALL write the bytes of wdata whose wstrb bit is 1 to word addr[31:2].
- No bytes are written when the burst error flag is set.
REQ-014 Read FSM states: R_IDLE (arready=1) and R_DATA.
- AR handshake latches the request; rvalid SHALL rise on the next cycle (one-cycle latency).
- A new beat is presented on each cycle where rvalid&&rready; rlast=1 on beat arlen.
- R_DATA->R_IDLE after the last beat handshake.
REQ-015 rdata, rid, rresp and rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-016 Address update per beat:
- INCR (2'b01): +4.
- FIXED (2'b00): unchanged.
- WRAP (2'b10) and 2'b11: treated as INCR with response SLVERR for every beat.
REQ-017 Bursts SHALL be allowed to cross 4KB boundaries; no boundary check is performed.
REQ-018 awsize/arsize other than 3'b010 SHALL cause SLVERR for the whole burst.
REQ-019 A beat address at or above MEM_WORDS*4 SHALL respond DECERR (2'b11) on that beat (read, rdata=0) or on B (write, write suppressed).
- Priority: DECERR > SLVERR > OKAY.
REQ-020 bid SHALL equal the latched awid; rid SHALL equal the latched arid.
REQ-021 A write beat and a read beat to the same word in the same cycle SHALL return the old data (read-first).

Reset
REQ-022 While rst_n=1, both FSMs SHALL go to IDLE and outputs SHALL be forced as follows:
- awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0.
- bresp=0, rresp=0, bid=0, rid=0, rdata=0.
REQ-023 The first cycle after release SHALL assert awready=1 and arready=1.
REQ-024 Memory contents SHALL NOT be reset; a reset during a burst SHALL abandon the burst with no B/R response, and already-written beats remain.

Structure
REQ-025 Shared package axi_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP) and response encodings (OKAY/EXOKAY/SLVERR/DECERR).
REQ-026 The storage array SHALL be a sub-module axi_sram_mem:
- one write port with 4-bit byte enables;
- one asynchronous read port;
- MEM_WORDS deep.

Verification
REQ-027 Write INCR awlen=3 at 0x1000 with data 1,2,3,4 and wstrb=4'hF, then read back the same burst -> bresp=OKAY, rdata 1,2,3,4, rlast only on beat 4.
REQ-028 Write 0xAABBCCDD with wstrb=4'b0101 over 0x0 -> readback 0x00BB00DD.
REQ-029 Read awlen=15 at 0x2000 with rready toggling 1,0,1,0 -> 16 beats, payload held while stalled, rid=arid=4'h5.
REQ-030 Write at address MEM_WORDS*4 -> bresp=DECERR and memory unchanged; awsize=3'b001 -> SLVERR.
REQ-031 Concurrent 4-beat write to 0x0 and 4-beat read of 0x0 -> read returns pre-write values and both responses OKAY.
REQ-032 Assert rst_n during W_DATA after beat 2 -> all valids low, awready=1 on the first cycle after release, beats 1-2 persist.
